fb_reader: RTL

Framebuffer scan-out reader: PLB master that walks the framebuffer raster (line-major, column-minor) with single-beat reads and pushes each 32-bit pixel into a downstream display FIFO. It is the read-side counterpart of the rasterizer framebuffer writer. It uses the same framebuffer base address and the same line/column address packing, and sits between the PLB master IPIF and the video-output FIFO.

---
 rtl/fb_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fb_reader.sv
// Framebuffer scan-out reader: walks the raster line-major with single-beat PLB reads and pushes pixels to the display FIFO.
// Optional FBR_VSYNC_START_EN: holds each new frame until a vsync high sample.
module fb_reader #(
  parameter logic [10:0] FB_BASE_ADDR = 11'b1001_0000_000,
  parameter int LINE_LEN     = 9,
  parameter int COL_LEN      = 10,
  parameter int NUM_LINES    = 480,
  parameter int NUM_COLS     = 640,
  parameter int C_MST_AWIDTH = 32,
  parameter int C_MST_DWIDTH = 32
) (
  input  logic                      PLB_clk,
  input  logic                      reset,
  input  logic                      Bus2IP_Reset,
  input  logic                      enable,
`ifdef FBR_VSYNC_START_EN
  input  logic                      vsync,
`endif
  output logic [0:C_MST_DWIDTH-1]   fifo_data,
  output logic                      fifo_wr_en,
  input  logic                      fifo_full,
  output logic                      frame_done,
  output logic                      rd_error,
  output logic                      IP2Bus_MstRd_Req,
  output logic                      IP2Bus_MstWr_Req,
  output logic                      IP2Bus_Mst_Lock,
  output logic                      IP2Bus_Mst_Reset,
  output logic [0:C_MST_AWIDTH-1]   IP2Bus_Mst_Addr,
  output logic [0:C_MST_DWIDTH/8-1] IP2Bus_Mst_BE,
  output logic [0:C_MST_DWIDTH-1]   IP2Bus_MstWr_d,
  output logic                      IP2Bus_MstRd_dst_rdy_n,
  input  logic                      Bus2IP_Mst_CmdAck,
  input  logic                      Bus2IP_Mst_Cmplt,
  input  logic                      Bus2IP_Mst_Error,
  input  logic                      Bus2IP_Mst_Rearbitrate,
  input  logic                      Bus2IP_Mst_Cmd_Timeout,
  input  logic [0:C_MST_DWIDTH-1]   Bus2IP_MstRd_d,
  input  logic                      Bus2IP_MstRd_src_rdy_n,
  input  logic                      Bus2IP_MstWr_dst_rdy_n
);

  localparam logic [LINE_LEN-1:0] LINE_LAST = LINE_LEN'(NUM_LINES - 1);
  localparam logic [COL_LEN-1:0]  COL_LAST  = COL_LEN'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ        = 3'd1,
    WAIT       = 3'd2,
    PUSH       = 3'd3,
    WAIT_VSYNC = 3'd4
  } state_t;

  state_t                  state;
  logic [LINE_LEN-1:0]     line;
  logic [COL_LEN-1:0]      col;
  logic [0:C_MST_DWIDTH-1] pixel;
  logic                    rst;

  assign rst = reset | Bus2IP_Reset;

  assign IP2Bus_MstWr_Req = 1'b0;
  assign IP2Bus_Mst_Lock  = 1'b0;
  assign IP2Bus_Mst_Reset = 1'b0;
  assign IP2Bus_Mst_BE    = '1;
  assign IP2Bus_MstWr_d   = '0;
  assign IP2Bus_Mst_Addr  = {FB_BASE_ADDR, line, col, 2'b00};

  // Rearbitrate needs no action: Req simply stays up in REQ until CmdAck.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, Bus2IP_Mst_Rearbitrate, Bus2IP_MstWr_dst_rdy_n};

  always_ff @(posedge PLB_clk) begin
    if (rst) begin
      state                  <= IDLE;
      line                   <= '0;
      col                    <= '0;
      pixel                  <= '0;
      fifo_data              <= '0;
      fifo_wr_en             <= 1'b0;
      frame_done             <= 1'b0;
      rd_error               <= 1'b0;
      IP2Bus_MstRd_Req       <= 1'b0;
      IP2Bus_MstRd_dst_rdy_n <= 1'b1;
    end else begin
      fifo_wr_en <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !fifo_full) begin
            state            <= REQ;
            IP2Bus_MstRd_Req <= 1'b1;
          end
        end
        REQ: begin
          if (Bus2IP_Mst_Cmd_Timeout) begin
            IP2Bus_MstRd_Req <= 1'b0;
            pixel            <= '0;
            rd_error         <= 1'b1;
            state            <= PUSH;
          end else if (Bus2IP_Mst_CmdAck) begin
            IP2Bus_MstRd_Req <= 1'b0;
            // Ack and completion together collapse the WAIT phase.
            if (Bus2IP_Mst_Cmplt) begin
              state <= PUSH;
              if (Bus2IP_Mst_Error) begin
                pixel    <= '0;
                rd_error <= 1'b1;
              end else if (!Bus2IP_MstRd_src_rdy_n) begin
                pixel <= Bus2IP_MstRd_d;
              end
            end else begin
              state                  <= WAIT;
              IP2Bus_MstRd_dst_rdy_n <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (!Bus2IP_MstRd_src_rdy_n) pixel <= Bus2IP_MstRd_d;
          if (Bus2IP_Mst_Cmplt) begin
            IP2Bus_MstRd_dst_rdy_n <= 1'b1;
            state                  <= PUSH;
            if (Bus2IP_Mst_Error || Bus2IP_Mst_Cmd_Timeout) begin
              pixel    <= '0;
              rd_error <= 1'b1;
            end
          end
        end
        PUSH: begin
          if (!fifo_full) begin
            fifo_wr_en <= 1'b1;
            fifo_data  <= pixel;
            state      <= IDLE;
            if (col == COL_LAST) begin
              col <= '0;
              if (line == LINE_LAST) begin
                line       <= '0;
                frame_done <= 1'b1;
`ifdef FBR_VSYNC_START_EN
                state      <= WAIT_VSYNC;
`endif
              end else begin
                line <= line + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
`ifdef FBR_VSYNC_START_EN
        WAIT_VSYNC: begin
          if (vsync) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
